// File: rtl/cache_pkg.sv
// Shared types and tree-PLRU helpers for the cache tag store.
// Helpers work on a tree sized for up to 8 ways; callers pass the tree depth.
package cache_pkg;

    localparam int MAX_NODES  = 7;
    localparam int MAX_LEVELS = 3;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } sweep_state_e;

    typedef logic [MAX_NODES-1:0]  plru_t;
    typedef logic [MAX_LEVELS-1:0] way_t;

    // Heap-ordered tree, node 0 is the root; each node on the path is pointed away from way.
    function automatic plru_t plru_touch(input plru_t plru, input way_t way, input logic [1:0] levels);
        plru_t      r;
        way_t       path;
        way_t       dir;
        logic [2:0] node;
        logic [1:0] sh;
        r = plru;
        for (int l = 0; l < int'(levels); l++) begin
            sh      = levels - 2'(l);
            path    = way >> sh;
            node    = 3'((1 << l) - 1) + path;
            dir     = way >> (sh - 2'd1);
            r[node] = ~dir[0];
        end
        return r;
    endfunction

    function automatic way_t plru_victim(input plru_t plru, input logic [1:0] levels);
        way_t       way;
        logic [2:0] node;
        logic       b;
        way  = '0;
        node = '0;
        for (int l = 0; l < int'(levels); l++) begin
            b    = plru[node];
            way  = {way[1:0], b};
            node = {node[1:0], 1'b0} + 3'd1 + {2'b00, b};
        end
        return way;
    endfunction

endpackage

// File: rtl/cache_tag_array_ram.sv
// Simple dual-port synchronous tag RAM: one write port, one registered read port.
module tag_sdp_ram #(
    parameter int ADDR_BITS = 7,
    parameter int DATA_BITS = 21
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [DATA_BITS-1:0] rd_data
);
    localparam int DEPTH = 1 << ADDR_BITS;

    logic [DATA_BITS-1:0] mem_r [DEPTH];
    logic [DATA_BITS-1:0] rd_data_r;

    // Storage write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Read register holds its value between read requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_r <= '0;
        end else if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/cache_tag_array.sv
// N-way set-associative tag store with per-way valid/dirty, per-set tree PLRU,
// a self-clearing init/flush sweep and an optional write-to-read bypass.
module cache_tag_array
    import cache_pkg::*;
#(
    parameter int NUM_WAYS      = 2,
    parameter int SET_BITS      = 7,
    parameter int TAG_BITS      = 21,
    parameter int CLEAR_ON_INIT = 1,
    parameter int ENABLE_BYPASS = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         init_busy,
    input  logic                         flush_req,
    input  logic                         rd_en,
    input  logic [SET_BITS-1:0]          rd_set,
    input  logic [TAG_BITS-1:0]          rd_cmp_tag,
    output logic [NUM_WAYS*TAG_BITS-1:0] rd_tags,
    output logic [NUM_WAYS-1:0]          rd_valid,
    output logic [NUM_WAYS-1:0]          rd_dirty,
    output logic [NUM_WAYS-2:0]          rd_plru,
    output logic [$clog2(NUM_WAYS)-1:0]  rd_victim,
    output logic [NUM_WAYS-1:0]          rd_hit,
    input  logic                         wr_en,
    input  logic [SET_BITS-1:0]          wr_set,
    input  logic [NUM_WAYS-1:0]          wr_way_mask,
    input  logic [TAG_BITS-1:0]          wr_tag,
    input  logic                         wr_valid,
    input  logic                         wr_dirty,
    input  logic                         touch_en,
    input  logic [SET_BITS-1:0]          touch_set,
    input  logic [$clog2(NUM_WAYS)-1:0]  touch_way
);
    localparam int                  WAY_BITS = $clog2(NUM_WAYS);
    localparam int                  DEPTH    = 1 << SET_BITS;
    localparam logic [1:0]          LEVELS   = 2'(WAY_BITS);
    localparam logic [SET_BITS-1:0] LAST_SET = '1;

    sweep_state_e        state_r, state_nx;
    logic [SET_BITS-1:0] cnt_r, cnt_nx;
    logic                init_busy_r;
    logic                sweep_s, rd_go_s, wr_go_s, touch_go_s;

    logic [NUM_WAYS-1:0] valid_r [DEPTH];
    logic [NUM_WAYS-1:0] dirty_r [DEPTH];
    logic [NUM_WAYS-2:0] plru_r  [DEPTH];

    plru_t               touch_full_s, tree_full_s;
    way_t                tree_way_s;
    logic [NUM_WAYS-2:0] touch_plru_s, rd_plru_nx, rd_plru_r;
    logic [NUM_WAYS-1:0] wr_byp_mask_s, rd_valid_nx, rd_dirty_nx;
    logic [NUM_WAYS-1:0] rd_valid_r, rd_dirty_r, byp_mask_r, rd_hit_s;
    logic [TAG_BITS-1:0] byp_tag_r, cmp_tag_r;
    logic [TAG_BITS-1:0] ram_q_s [NUM_WAYS];
    logic [TAG_BITS-1:0] tag_s   [NUM_WAYS];
    logic [WAY_BITS-1:0] first_inv_s, rd_victim_s;
    logic                found_inv_s;

    assign sweep_s    = (state_r == ST_SWEEP);
    assign rd_go_s    = rd_en && !init_busy_r;
    assign wr_go_s    = wr_en && !init_busy_r;
    assign touch_go_s = touch_en && !init_busy_r;

    // Sweep next-state: flush restarts the counter, last set returns to idle.
    always_comb begin
        state_nx = state_r;
        cnt_nx   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (flush_req) begin
                    state_nx = ST_SWEEP;
                    cnt_nx   = '0;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_SWEEP: begin
                if (flush_req) begin
                    cnt_nx = '0;
                end else if (cnt_r == LAST_SET) begin
                    state_nx = ST_IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt_r + 1'b1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Sweep state register; reset arms the first sweep when enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= (CLEAR_ON_INIT != 0) ? ST_SWEEP : ST_IDLE;
            cnt_r       <= '0;
            init_busy_r <= (CLEAR_ON_INIT != 0);
        end else begin
            state_r     <= state_nx;
            cnt_r       <= cnt_nx;
            init_busy_r <= (state_nx == ST_SWEEP);
        end
    end

    // PLRU update for the touched set; also reused as the bypass value.
    always_comb begin
        touch_full_s = plru_touch(plru_t'(plru_r[touch_set]), way_t'(touch_way), LEVELS);
        touch_plru_s = touch_full_s[NUM_WAYS-2:0];
    end

    // Status flops: the sweep is the only clearing path outside reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_r[i] <= '0;
                dirty_r[i] <= '0;
                plru_r[i]  <= '0;
            end
        end else if (sweep_s) begin
            valid_r[cnt_r] <= '0;
            dirty_r[cnt_r] <= '0;
            plru_r[cnt_r]  <= '0;
        end else begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (wr_go_s && wr_way_mask[w]) begin
                    valid_r[wr_set][w] <= wr_valid;
                    dirty_r[wr_set][w] <= wr_dirty;
                end
            end
            if (touch_go_s) begin
                plru_r[touch_set] <= touch_plru_s;
            end
        end
    end

    // Read-side bypass selection for a same-cycle write/touch to the read set.
    always_comb begin
        wr_byp_mask_s = '0;
        rd_plru_nx    = plru_r[rd_set];
        rd_valid_nx   = valid_r[rd_set];
        rd_dirty_nx   = dirty_r[rd_set];
        if ((ENABLE_BYPASS != 0) && wr_en && (wr_set == rd_set)) begin
            wr_byp_mask_s = wr_way_mask;
        end else begin
            wr_byp_mask_s = '0;
        end
        if ((ENABLE_BYPASS != 0) && touch_en && (touch_set == rd_set)) begin
            rd_plru_nx = touch_plru_s;
        end else begin
            rd_plru_nx = plru_r[rd_set];
        end
        for (int w = 0; w < NUM_WAYS; w++) begin
            rd_valid_nx[w] = wr_byp_mask_s[w] ? wr_valid : valid_r[rd_set][w];
            rd_dirty_nx[w] = wr_byp_mask_s[w] ? wr_dirty : dirty_r[rd_set][w];
        end
    end

    // Read result registers, held until the next accepted read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_r <= '0;
            rd_dirty_r <= '0;
            rd_plru_r  <= '0;
            byp_mask_r <= '0;
            byp_tag_r  <= '0;
            cmp_tag_r  <= '0;
        end else if (rd_go_s) begin
            rd_valid_r <= rd_valid_nx;
            rd_dirty_r <= rd_dirty_nx;
            rd_plru_r  <= rd_plru_nx;
            byp_mask_r <= wr_byp_mask_s;
            byp_tag_r  <= wr_tag;
            cmp_tag_r  <= rd_cmp_tag;
        end
    end

    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
        tag_sdp_ram #(
            .ADDR_BITS (SET_BITS),
            .DATA_BITS (TAG_BITS)
        ) u_ram (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (sweep_s || (wr_go_s && wr_way_mask[w])),
            .wr_addr (sweep_s ? cnt_r : wr_set),
            .wr_data (sweep_s ? {TAG_BITS{1'b0}} : wr_tag),
            .rd_en   (rd_go_s),
            .rd_addr (rd_set),
            .rd_data (ram_q_s[w])
        );
        assign tag_s[w]                         = byp_mask_r[w] ? byp_tag_r : ram_q_s[w];
        assign rd_tags[w*TAG_BITS +: TAG_BITS]  = tag_s[w];
    end

    // Hit compare and victim pick on the registered read result.
    always_comb begin
        rd_hit_s    = '0;
        first_inv_s = '0;
        found_inv_s = 1'b0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            rd_hit_s[w] = rd_valid_r[w] && (tag_s[w] == cmp_tag_r);
            if (!rd_valid_r[w] && !found_inv_s) begin
                found_inv_s = 1'b1;
                first_inv_s = WAY_BITS'(w);
            end else begin
                found_inv_s = found_inv_s;
            end
        end
        tree_full_s = plru_t'(rd_plru_r);
        tree_way_s  = plru_victim(tree_full_s, LEVELS);
        rd_victim_s = found_inv_s ? first_inv_s : tree_way_s[WAY_BITS-1:0];
    end

    assign init_busy = init_busy_r;
    assign rd_valid  = rd_valid_r;
    assign rd_dirty  = rd_dirty_r;
    assign rd_plru   = rd_plru_r;
    assign rd_victim = rd_victim_s;
    assign rd_hit    = rd_hit_s;

endmodule

// File: tb/tb_cache_tag_array.sv
// Scoreboard bench: a 2-way bypassing instance and a 4-way non-bypassing instance.
module tb_cache_tag_array;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 2-way, bypass enabled
    logic        busy2, flush2, rd_en2, wr_en2, wr_valid2, wr_dirty2, touch_en2;
    logic [6:0]  rd_set2, wr_set2, touch_set2;
    logic [20:0] rd_cmp2, wr_tag2;
    logic [41:0] rd_tags2;
    logic [1:0]  rd_valid2, rd_dirty2, rd_hit2, wr_mask2;
    logic [0:0]  rd_plru2, rd_victim2, touch_way2;
    // 4-way, bypass disabled
    logic        busy4, flush4, rd_en4, wr_en4, wr_valid4, wr_dirty4, touch_en4;
    logic [6:0]  rd_set4, wr_set4, touch_set4;
    logic [20:0] rd_cmp4, wr_tag4;
    logic [83:0] rd_tags4;
    logic [3:0]  rd_valid4, rd_dirty4, rd_hit4, wr_mask4;
    logic [2:0]  rd_plru4;
    logic [1:0]  rd_victim4, touch_way4;

    cache_tag_array dut2 (
        .clk(clk), .rst(rst), .init_busy(busy2), .flush_req(flush2),
        .rd_en(rd_en2), .rd_set(rd_set2), .rd_cmp_tag(rd_cmp2),
        .rd_tags(rd_tags2), .rd_valid(rd_valid2), .rd_dirty(rd_dirty2),
        .rd_plru(rd_plru2), .rd_victim(rd_victim2), .rd_hit(rd_hit2),
        .wr_en(wr_en2), .wr_set(wr_set2), .wr_way_mask(wr_mask2), .wr_tag(wr_tag2),
        .wr_valid(wr_valid2), .wr_dirty(wr_dirty2),
        .touch_en(touch_en2), .touch_set(touch_set2), .touch_way(touch_way2)
    );

    cache_tag_array #(.NUM_WAYS(4), .ENABLE_BYPASS(0)) dut4 (
        .clk(clk), .rst(rst), .init_busy(busy4), .flush_req(flush4),
        .rd_en(rd_en4), .rd_set(rd_set4), .rd_cmp_tag(rd_cmp4),
        .rd_tags(rd_tags4), .rd_valid(rd_valid4), .rd_dirty(rd_dirty4),
        .rd_plru(rd_plru4), .rd_victim(rd_victim4), .rd_hit(rd_hit4),
        .wr_en(wr_en4), .wr_set(wr_set4), .wr_way_mask(wr_mask4), .wr_tag(wr_tag4),
        .wr_valid(wr_valid4), .wr_dirty(wr_dirty4),
        .touch_en(touch_en4), .touch_set(touch_set4), .touch_way(touch_way4)
    );

    typedef struct {
        string       name;
        logic [83:0] tags;
        logic [3:0]  valid;
        logic [3:0]  dirty;
        logic [3:0]  hit;
        logic [2:0]  plru;
        logic [1:0]  victim;
    } exp_t;

    exp_t q2[$];
    exp_t q4[$];
    int   errors = 0;
    int   checks = 0;
    logic acc2 = 1'b0;
    logic acc4 = 1'b0;

    function automatic exp_t mk(string nm, logic [83:0] tags, logic [3:0] v, logic [3:0] d,
                                logic [3:0] h, logic [2:0] p, logic [1:0] vic);
        exp_t e;
        e.name = nm; e.tags = tags; e.valid = v; e.dirty = d; e.hit = h; e.plru = p; e.victim = vic;
        return e;
    endfunction

    function automatic logic [127:0] pack(exp_t e);
        return 128'({e.tags, e.valid, e.dirty, e.hit, e.plru, e.victim});
    endfunction

    task automatic check(string nm, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // A response is presented in the cycle after an accepted read.
    always @(posedge clk) begin
        acc2 <= rd_en2 && !busy2 && !rst;
        acc4 <= rd_en4 && !busy4 && !rst;
    end

    always @(negedge clk) begin
        exp_t e, a;
        if (acc2) begin
            a = mk("", 84'(rd_tags2), 4'(rd_valid2), 4'(rd_dirty2), 4'(rd_hit2), 3'(rd_plru2), 2'(rd_victim2));
            if (q2.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_rsp2: got response %h, expected none", pack(a));
            end else begin
                e = q2.pop_front();
                check(e.name, pack(a), pack(e));
            end
        end
        if (acc4) begin
            a = mk("", rd_tags4, rd_valid4, rd_dirty4, rd_hit4, rd_plru4, rd_victim4);
            if (q4.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_rsp4: got response %h, expected none", pack(a));
            end else begin
                e = q4.pop_front();
                check(e.name, pack(a), pack(e));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        flush2 = 1'b0; rd_en2 = 1'b0; wr_en2 = 1'b0; touch_en2 = 1'b0;
        flush4 = 1'b0; rd_en4 = 1'b0; wr_en4 = 1'b0; touch_en4 = 1'b0;
    endtask

    task automatic rd2(input logic [6:0] s, input logic [20:0] c);
        rd_en2 = 1'b1; rd_set2 = s; rd_cmp2 = c;
    endtask

    task automatic rd4(input logic [6:0] s, input logic [20:0] c);
        rd_en4 = 1'b1; rd_set4 = s; rd_cmp4 = c;
    endtask

    task automatic wr2(input logic [6:0] s, input logic [1:0] m, input logic [20:0] t,
                       input logic v, input logic d);
        wr_en2 = 1'b1; wr_set2 = s; wr_mask2 = m; wr_tag2 = t; wr_valid2 = v; wr_dirty2 = d;
    endtask

    task automatic wr4(input logic [6:0] s, input logic [3:0] m, input logic [20:0] t,
                       input logic v, input logic d);
        wr_en4 = 1'b1; wr_set4 = s; wr_mask4 = m; wr_tag4 = t; wr_valid4 = v; wr_dirty4 = d;
    endtask

    task automatic touch4(input logic [6:0] s, input logic [1:0] w);
        touch_en4 = 1'b1; touch_set4 = s; touch_way4 = w;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n2, n4, n;
        int init_sets[3];
        init_sets = '{0, 127, 64};
        rst = 1'b1;
        clr();
        rd_set2 = '0; rd_cmp2 = '0; wr_set2 = '0; wr_mask2 = '0; wr_tag2 = '0;
        wr_valid2 = 1'b0; wr_dirty2 = 1'b0; touch_set2 = '0; touch_way2 = '0;
        rd_set4 = '0; rd_cmp4 = '0; wr_set4 = '0; wr_mask4 = '0; wr_tag4 = '0;
        wr_valid4 = 1'b0; wr_dirty4 = 1'b0; touch_set4 = '0; touch_way4 = '0;
        repeat (3) tick();
        check("reset_rd2", 128'({rd_tags2, rd_valid2, rd_dirty2, rd_plru2, rd_victim2, rd_hit2}), 128'd0);
        check("reset_rd4", 128'({rd_tags4, rd_valid4, rd_dirty4, rd_plru4, rd_victim4, rd_hit4}), 128'd0);
        rst = 1'b0;

        n2 = 0; n4 = 0; n = 0;
        while ((busy2 || busy4) && n < 1000) begin
            if (busy2) n2++;
            if (busy4) n4++;
            n++;
            tick();
        end
        check("init_busy_cycles2", 128'(n2), 128'd128);
        check("init_busy_cycles4", 128'(n4), 128'd128);

        // after init every set reads empty
        foreach (init_sets[i]) begin
            rd2(7'(init_sets[i]), 21'h0);
            q2.push_back(mk($sformatf("init_rd2_set%0d", init_sets[i]), 84'h0, 4'h0, 4'h0, 4'h0, 3'h0, 2'h0));
            tick();
        end
        clr();
        rd4(7'd3, 21'h0);
        q4.push_back(mk("init_rd4_set3", 84'h0, 4'h0, 4'h0, 4'h0, 3'h0, 2'h0));
        tick(); clr();

        // write then read back on the 2-way instance
        wr2(7'd5, 2'b10, 21'h1ABCD, 1'b1, 1'b1);
        tick(); clr();
        rd2(7'd5, 21'h1ABCD);
        q2.push_back(mk("wr_rd_set5", {21'h1ABCD, 21'h0}, 4'b0010, 4'b0010, 4'b0010, 3'h0, 2'd0));
        tick(); clr();

        // same-cycle write/read with bypass, then the committed value
        wr2(7'd9, 2'b01, 21'h00042, 1'b1, 1'b0);
        rd2(7'd9, 21'h00042);
        q2.push_back(mk("bypass_set9", {21'h0, 21'h00042}, 4'b0001, 4'b0000, 4'b0001, 3'h0, 2'd1));
        tick(); clr();
        rd2(7'd9, 21'h00042);
        q2.push_back(mk("commit_set9", {21'h0, 21'h00042}, 4'b0001, 4'b0000, 4'b0001, 3'h0, 2'd1));
        tick(); clr();

        // PLRU bypass: touching way 0 points the root at way 1
        touch_en2 = 1'b1; touch_set2 = 7'd5; touch_way2 = 1'b0;
        rd2(7'd5, 21'h1ABCD);
        q2.push_back(mk("plru_bypass_set5", {21'h1ABCD, 21'h0}, 4'b0010, 4'b0010, 4'b0010, 3'h1, 2'd0));
        tick(); clr();

        // flush: dropped write and ignored read during the sweep
        flush2 = 1'b1;
        tick(); clr();
        n = 0;
        while (busy2 && n < 1000) begin
            wr_en2 = (n == 64); wr_set2 = 7'd5; wr_mask2 = 2'b11; wr_tag2 = 21'h00055;
            wr_valid2 = 1'b1; wr_dirty2 = 1'b1;
            rd_en2 = (n == 70); rd_set2 = 7'd0; rd_cmp2 = 21'h0;
            n++;
            tick();
        end
        clr();
        check("flush_busy_cycles", 128'(n), 128'd128);
        check("hold_during_busy", 128'({rd_valid2, rd_plru2}), 128'b101);
        rd2(7'd5, 21'h1ABCD);
        q2.push_back(mk("after_flush_set5", 84'h0, 4'h0, 4'h0, 4'h0, 3'h0, 2'd0));
        tick(); clr();

        // 4-way without bypass: old contents first, then the committed write
        wr4(7'd9, 4'b0001, 21'h00042, 1'b1, 1'b1);
        rd4(7'd9, 21'h00042);
        q4.push_back(mk("nobypass_set9", 84'h0, 4'h0, 4'h0, 4'h0, 3'h0, 2'd0));
        tick(); clr();
        rd4(7'd9, 21'h00042);
        q4.push_back(mk("commit4_set9", {21'h0, 21'h0, 21'h0, 21'h00042}, 4'b0001, 4'b0001, 4'b0001, 3'h0, 2'd1));
        tick(); clr();

        // PLRU walk in set 3 with all ways valid
        wr4(7'd3, 4'b1111, 21'h00003, 1'b1, 1'b0);
        tick(); clr();
        for (int w = 0; w < 4; w++) begin
            touch4(7'd3, 2'(w));
            tick();
        end
        clr();
        rd4(7'd3, 21'h00003);
        q4.push_back(mk("plru_after_0123", {4{21'h00003}}, 4'b1111, 4'b0000, 4'b1111, 3'b000, 2'd0));
        tick(); clr();
        touch4(7'd3, 2'd0);
        tick(); clr();
        rd4(7'd3, 21'h00003);
        q4.push_back(mk("plru_after_touch0", {4{21'h00003}}, 4'b1111, 4'b0000, 4'b1111, 3'b011, 2'd2));
        tick(); clr();

        // invalid-way priority; write and touch to the same set together
        wr4(7'd7, 4'b0101, 21'h00007, 1'b1, 1'b0);
        touch4(7'd7, 2'd0);
        tick(); clr();
        rd4(7'd7, 21'h00007);
        q4.push_back(mk("invalid_prio_set7", {21'h0, 21'h00007, 21'h0, 21'h00007}, 4'b0101, 4'b0000, 4'b0101, 3'b011, 2'd1));
        tick(); clr();

        // write and touch to different sets in one cycle
        wr4(7'd10, 4'b1111, 21'h0000A, 1'b1, 1'b0);
        touch4(7'd3, 2'd3);
        tick(); clr();
        rd4(7'd3, 21'h00003);
        q4.push_back(mk("touch3_set3", {4{21'h00003}}, 4'b1111, 4'b0000, 4'b1111, 3'b010, 2'd1));
        tick();
        rd4(7'd10, 21'h0000A);
        q4.push_back(mk("wr_set10", {4{21'h0000A}}, 4'b1111, 4'b0000, 4'b1111, 3'b000, 2'd0));
        tick(); clr();

        repeat (3) tick();
        check("q2_drained", 128'(q2.size()), 128'd0);
        check("q4_drained", 128'(q4.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
